tlb_walk_arbiter: RTL and testbench

TLB_WALK_ARBITER -- requirements
Module: tlb_walk_arbiter

---
 rtl/tlb_walk_arbiter.sv | 134 +++++++++++++
 tb/tb_tlb_walk_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_walk_arbiter.sv
// Shares one page walker between I-side and D-side TLB misses; grant/walk_req 1 cycle after a miss, fill 1 cycle after the response.
// Backpressure: walk_req held until walk_ready; misses wait in IDLE; one walk outstanding at a time.
package tlb_walk_pkg;
    typedef struct packed {
        logic [63:0] paddr;
        logic [1:0]  pgsize;
        logic        dirty;
        logic        readable;
        logic        writable;
        logic        executable;
        logic        user;
    } page_walk_rsp_t;
endpackage

module tlb_walk_arbiter
    import tlb_walk_pkg::*;
#(
    parameter int LG_WALK_CNT = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        i_miss_req,
    input  logic [63:0]                 i_miss_va,
    input  logic                        d_miss_req,
    input  logic [63:0]                 d_miss_va,
    output logic                        i_grant,
    output logic                        d_grant,
    output logic                        walk_req,
    output logic [63:0]                 walk_va,
    input  logic                        walk_ready,
    input  logic                        walk_rsp_valid,
    input  logic                        walk_fault,
    input  page_walk_rsp_t              page_walk_rsp,
    output logic                        itlb_replace,
    output logic                        dtlb_replace,
    output logic [63:0]                 replace_va,
    output page_walk_rsp_t              replace_rsp,
    output logic                        i_fault,
    output logic                        d_fault,
    output logic                        busy,
    output logic [(1<<LG_WALK_CNT)-1:0] i_walks,
    output logic [(1<<LG_WALK_CNT)-1:0] d_walks
);
    localparam int CW = 1 << LG_WALK_CNT;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t         state, state_nxt;
    logic           last_d;
    logic           squash;
    logic           grant_q;
    logic           side_d;
    logic           fault_q;
    logic [63:0]    va_q;
    page_walk_rsp_t rsp_q;
    logic [CW-1:0]  i_cnt, d_cnt;

    logic pick_d, start, accept, rsp_take, fill_live;

    // D wins only when alone or when I was granted last.
    assign pick_d    = d_miss_req && (!i_miss_req || !last_d);
    assign start     = (state == IDLE) && (i_miss_req || d_miss_req);
    assign accept    = (state == REQ) && walk_ready;
    assign rsp_take  = (state == WAIT) && walk_rsp_valid;
    assign fill_live = (state == FILL) && !clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            squash  <= 1'b0;
            last_d  <= 1'b1;
            grant_q <= 1'b0;
            side_d  <= 1'b0;
            fault_q <= 1'b0;
            va_q    <= '0;
            rsp_q   <= '0;
            i_cnt   <= '0;
            d_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= start;
            if (start) begin
                side_d <= pick_d;
                last_d <= pick_d;
                va_q   <= pick_d ? d_miss_va : i_miss_va;
            end
            // A flush after the walker took the request must still swallow its response.
            if (rsp_take)
                squash <= 1'b0;
            else if (clear && (accept || state == WAIT))
                squash <= 1'b1;
            if (rsp_take) begin
                rsp_q   <= page_walk_rsp;
                fault_q <= walk_fault;
            end
            if (fill_live) begin
                if (side_d) d_cnt <= d_cnt + 1'b1;
                else        i_cnt <= i_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (walk_ready)  state_nxt = WAIT;
                else if (clear)  state_nxt = IDLE;
            end
            WAIT: if (walk_rsp_valid) state_nxt = (squash || clear) ? IDLE : FILL;
            FILL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_grant      = grant_q && !side_d;
        d_grant      = grant_q && side_d;
        walk_req     = (state == REQ);
        busy         = (state != IDLE);
        itlb_replace = fill_live && !fault_q && !side_d;
        dtlb_replace = fill_live && !fault_q && side_d;
        i_fault      = fill_live && fault_q && !side_d;
        d_fault      = fill_live && fault_q && side_d;
    end

    assign walk_va     = va_q;
    assign replace_va  = va_q;
    assign replace_rsp = rsp_q;
    assign i_walks     = i_cnt;
    assign d_walks     = d_cnt;
endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Directed and random walks against a transaction-level model of the walk arbiter.
module tb_tlb_walk_arbiter;
    import tlb_walk_pkg::*;

    localparam int LG = 2;
    localparam int CW = 1 << LG;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           clear = 1'b0;
    logic           i_miss_req = 1'b0, d_miss_req = 1'b0;
    logic [63:0]    i_miss_va = '0, d_miss_va = '0;
    logic           i_grant, d_grant, walk_req, walk_ready = 1'b0;
    logic [63:0]    walk_va, replace_va;
    logic           walk_rsp_valid = 1'b0, walk_fault = 1'b0;
    page_walk_rsp_t page_walk_rsp = '0, replace_rsp;
    logic           itlb_replace, dtlb_replace, i_fault, d_fault, busy;
    logic [CW-1:0]  i_walks, d_walks;

    tlb_walk_arbiter #(.LG_WALK_CNT(LG)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_miss_req(i_miss_req), .i_miss_va(i_miss_va),
        .d_miss_req(d_miss_req), .d_miss_va(d_miss_va),
        .i_grant(i_grant), .d_grant(d_grant),
        .walk_req(walk_req), .walk_va(walk_va), .walk_ready(walk_ready),
        .walk_rsp_valid(walk_rsp_valid), .walk_fault(walk_fault), .page_walk_rsp(page_walk_rsp),
        .itlb_replace(itlb_replace), .dtlb_replace(dtlb_replace),
        .replace_va(replace_va), .replace_rsp(replace_rsp),
        .i_fault(i_fault), .d_fault(d_fault), .busy(busy),
        .i_walks(i_walks), .d_walks(d_walks)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: completed walks per side and which side won last.
    int m_i_walks = 0;
    int m_d_walks = 0;
    bit m_last_d  = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {i_grant, d_grant, itlb_replace, dtlb_replace, i_fault, d_fault};
    endfunction

    task automatic chk_counts();
        chk("i_walks", i_walks, m_i_walks % (1 << CW));
        chk("d_walks", d_walks, m_d_walks % (1 << CW));
    endtask

    // mode: 0 none, 1 clear in REQ before accept, 2 clear in WAIT, 3 clear in FILL, 4 clear in accept cycle
    task automatic run_walk(input bit ri, input bit rd, input logic [63:0] vai, input logic [63:0] vad,
                            input int rdly, input int sdly, input bit flt, input int mode,
                            input bit idle_clr, input page_walk_rsp_t pl);
        bit win_i, squashed, cf;
        logic [63:0] exp_va;
        win_i    = ri && (!rd || m_last_d);
        m_last_d = !win_i;
        exp_va   = win_i ? vai : vad;
        squashed = (mode == 2) || (mode == 4);

        @(negedge clk);
        i_miss_req = ri; d_miss_req = rd; i_miss_va = vai; d_miss_va = vad;
        clear = idle_clr; walk_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_walk_req", walk_req, 1'b0);

        for (int k = 0; k <= rdly; k++) begin
            @(negedge clk);
            if (k > 0) begin i_miss_req = 1'b0; d_miss_req = 1'b0; end
            walk_ready = (k == rdly);
            clear = (mode == 1 && k == rdly - 1) || (mode == 4 && k == rdly);
            #1;
            chk("req_walk_req", walk_req, 1'b1);
            chk("req_walk_va", walk_va, exp_va);
            chk("req_grants", {i_grant, d_grant}, (k == 0) ? {win_i, !win_i} : 2'b00);
            if (mode == 1 && clear) break;
        end

        if (mode == 1) begin
            @(negedge clk);
            clear = 1'b0; walk_ready = 1'b0; i_miss_req = 1'b0; d_miss_req = 1'b0;
            #1;
            chk("abort_walk_req", walk_req, 1'b0);
            chk("abort_busy", busy, 1'b0);
            chk("abort_strobes", strobes(), 6'b0);
            chk_counts();
            return;
        end

        for (int k = 0; k <= sdly; k++) begin
            @(negedge clk);
            i_miss_req = 1'b0; d_miss_req = 1'b0; walk_ready = 1'b0;
            clear = (mode == 2 && k == 0);
            walk_rsp_valid = (k == sdly);
            walk_fault = flt;
            page_walk_rsp = pl;
            #1;
            chk("wait_walk_req", walk_req, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_strobes", strobes(), 6'b0);
        end

        @(negedge clk);
        walk_rsp_valid = 1'b0; walk_fault = 1'b0; page_walk_rsp = '0;
        cf = (mode == 3);
        clear = cf;
        #1;
        if (squashed) begin
            chk("squash_busy", busy, 1'b0);
            chk("squash_strobes", strobes(), 6'b0);
        end else begin
            chk("fill_busy", busy, 1'b1);
            chk("fill_strobes", strobes(),
                {2'b00, win_i & !flt & !cf, !win_i & !flt & !cf, win_i & flt & !cf, !win_i & flt & !cf});
            if (!flt && !cf) begin
                chk("fill_va", replace_va, exp_va);
                chk("fill_rsp", replace_rsp, pl);
            end
            if (!cf) begin
                if (win_i) m_i_walks++;
                else       m_d_walks++;
            end
            @(negedge clk);
            clear = 1'b0;
            #1;
            chk("post_fill_busy", busy, 1'b0);
            chk("post_fill_strobes", strobes(), 6'b0);
        end
        clear = 1'b0;
        chk_counts();
    endtask

    function automatic page_walk_rsp_t rand_pl();
        page_walk_rsp_t p;
        p.paddr  = {$urandom, $urandom};
        p.pgsize = 2'($urandom_range(0, 3));
        {p.dirty, p.readable, p.writable, p.executable, p.user} = 5'($urandom_range(0, 31));
        return p;
    endfunction

    initial begin
        page_walk_rsp_t pl;
        int p, m, rdly, sdly, mode;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_walk_req", walk_req, 1'b0);
        chk("rst_strobes", strobes(), 6'b0);
        chk_counts();
        @(negedge clk);
        reset = 1'b1;

        // Contention right after reset: I first, then D on the next contention.
        run_walk(1, 1, 64'h1000_a000, 64'h2000_b000, 0, 1, 0, 0, 0, rand_pl());
        run_walk(1, 1, 64'h1000_c000, 64'h2000_d000, 0, 1, 0, 0, 0, rand_pl());

        pl = '0; pl.paddr = 64'h8000_1000; pl.pgsize = 2'd2; pl.readable = 1'b1;
        run_walk(0, 1, 64'h0, 64'h7fff_3000, 3, 5, 0, 0, 0, pl);
        run_walk(1, 0, 64'h4000_0000, 64'h0, 1, 2, 1, 0, 0, rand_pl());
        run_walk(1, 0, 64'h4000_1000, 64'h0, 0, 3, 0, 2, 0, rand_pl());
        run_walk(0, 1, 64'h0, 64'h5000_2000, 2, 1, 0, 1, 0, rand_pl());
        run_walk(0, 1, 64'h0, 64'h5000_3000, 0, 1, 0, 0, 1, rand_pl());
        run_walk(1, 1, 64'h6000_0000, 64'h6000_1000, 1, 0, 0, 3, 0, rand_pl());
        run_walk(1, 1, 64'h6000_2000, 64'h6000_3000, 2, 2, 0, 4, 0, rand_pl());

        for (int it = 0; it < 70; it++) begin
            p    = $urandom_range(1, 3);
            rdly = $urandom_range(0, 3);
            sdly = $urandom_range(0, 4);
            m    = $urandom_range(0, 9);
            mode = (m < 5) ? 0 : m - 5;
            if (mode == 1 && rdly == 0) rdly = 1;
            if (mode == 2 && sdly == 0) sdly = 1;
            run_walk(p[0], p[1], {$urandom, $urandom}, {$urandom, $urandom}, rdly, sdly,
                     1'($urandom_range(0, 1)), mode, 1'($urandom_range(0, 1)), rand_pl());
        end

        // Reset while a walk is in WAIT, then a stale response.
        @(negedge clk);
        i_miss_req = 1'b1; i_miss_va = 64'h9000_0000;
        @(negedge clk);
        i_miss_req = 1'b0; walk_ready = 1'b1;
        @(negedge clk);
        walk_ready = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; walk_rsp_valid = 1'b1; page_walk_rsp = rand_pl();
        m_i_walks = 0; m_d_walks = 0; m_last_d = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_strobes", strobes(), 6'b0);
        @(negedge clk);
        walk_rsp_valid = 1'b0;
        #1;
        chk("rst_stale_busy", busy, 1'b0);
        chk("rst_stale_strobes", strobes(), 6'b0);
        chk_counts();
        run_walk(1, 1, 64'h1111_0000, 64'h2222_0000, 0, 0, 0, 0, 0, rand_pl());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
